// File: rtl/mannix_mem_pkg.sv
// ---------------------------------------------------------------------------
// mannix_mem_pkg
//   Shared constants and types for the mannix memory-farm read responder.
//   - MM_* constants: default widths for the client and SRAM sides.
//   - MM_MAX_SRAM_LAT: largest SRAM read latency the responder supports.
//   - addr_t / word_t: word address and data word types.
//   - resp_state_e: responder FSM states.
// ---------------------------------------------------------------------------
package mannix_mem_pkg;

  localparam int MM_ADDR_WIDTH        = 19;
  localparam int MM_WORD_WIDTH        = 8;
  localparam int MM_NUM_WORDS_IN_LINE = 32;
  localparam int MM_SIZE_W            = $clog2(MM_NUM_WORDS_IN_LINE + 1);
  localparam int MM_MAX_SRAM_LAT      = 4;

  typedef logic [MM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [MM_WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } resp_state_e;

endpackage

// File: rtl/mannix_mem_read_responder_if.sv
// ---------------------------------------------------------------------------
// mannix_mem_read_responder_if
//   Bundles the client read port and the SRAM read port of one responder.
//   Client side : rd_req, rd_addr, rd_size -> rd_gnt, rd_data, rd_valid, rd_busy
//   SRAM side   : sram_cs, sram_addr -> sram_rdata
//   modport slave  : the responder.
//   modport master : the surrounding environment (client plus SRAM bank).
// ---------------------------------------------------------------------------
interface mannix_mem_read_responder_if
  import mannix_mem_pkg::*;
#(
  parameter int ADDR_WIDTH        = MM_ADDR_WIDTH,
  parameter int WORD_WIDTH        = MM_WORD_WIDTH,
  parameter int NUM_WORDS_IN_LINE = MM_NUM_WORDS_IN_LINE,
  parameter int SIZE_W            = $clog2(NUM_WORDS_IN_LINE + 1)
);

  logic                                rd_req;
  logic [ADDR_WIDTH-1:0]               rd_addr;
  logic [SIZE_W-1:0]                   rd_size;
  logic                                rd_gnt;
  logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0] rd_data;
  logic                                rd_valid;
  logic                                rd_busy;
  logic                                sram_cs;
  logic [ADDR_WIDTH-1:0]               sram_addr;
  logic [WORD_WIDTH-1:0]               sram_rdata;

  modport slave (
    input  rd_req, rd_addr, rd_size, sram_rdata,
    output rd_gnt, rd_data, rd_valid, rd_busy, sram_cs, sram_addr
  );

  modport master (
    output rd_req, rd_addr, rd_size, sram_rdata,
    input  rd_gnt, rd_data, rd_valid, rd_busy, sram_cs, sram_addr
  );

endinterface

// File: rtl/mannix_lat_pipe.sv
// ---------------------------------------------------------------------------
// mannix_lat_pipe
//   LAT-deep shift register of {valid, word index} that tracks SRAM reads in
//   flight. An entry pushed in cycle c is presented on out_* in cycle c+LAT,
//   the same cycle the SRAM returns that word.
//   Ports:
//     clk       clock
//     flush     asynchronous active-high clear of every stage
//     in_valid  a read is issued this cycle
//     in_idx    line word index of that read
//     out_valid returned word present this cycle
//     out_idx   line word index of the returned word
//     pending   entries remain that are not yet at the output stage; low
//               means the pipe is empty after the current cycle
// ---------------------------------------------------------------------------
module mannix_lat_pipe #(
  parameter int LAT   = 2,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             pending
);

  logic [LAT-1:0]   vld_reg;
  logic [IDX_W-1:0] idx_reg [LAT];

  always_ff @(posedge clk or posedge flush) begin
    if (flush) begin
      vld_reg <= '0;
      for (int i = 0; i < LAT; i++) begin
        idx_reg[i] <= '0;
      end
    end else begin
      vld_reg[0] <= in_valid;
      idx_reg[0] <= in_idx;
      for (int i = 1; i < LAT; i++) begin
        vld_reg[i] <= vld_reg[i-1];
        idx_reg[i] <= idx_reg[i-1];
      end
    end
  end

  assign out_valid = vld_reg[LAT-1];
  assign out_idx   = idx_reg[LAT-1];

  // The output stage is consumed this cycle, so only earlier stages count.
  generate
    if (LAT == 1) begin : g_single
      assign pending = 1'b0;
    end else begin : g_multi
      assign pending = |vld_reg[LAT-2:0];
    end
  endgenerate

endmodule

// File: rtl/mannix_mem_read_responder.sv
// ---------------------------------------------------------------------------
// mannix_mem_read_responder
//   Serves line-read requests from one accelerator client. A captured request
//   is turned into one SRAM word read per cycle; returned words are assembled
//   into a line and handed back with a single-cycle rd_valid.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous reset, active HIGH despite the name
//     bus    slave modport: client request/response and SRAM read port
//   Parameters:
//     SRAM_LAT  SRAM cs-to-rdata latency, 1..MM_MAX_SRAM_LAT
// ---------------------------------------------------------------------------
module mannix_mem_read_responder
  import mannix_mem_pkg::*;
#(
  parameter int ADDR_WIDTH        = MM_ADDR_WIDTH,
  parameter int WORD_WIDTH        = MM_WORD_WIDTH,
  parameter int NUM_WORDS_IN_LINE = MM_NUM_WORDS_IN_LINE,
  parameter int SRAM_LAT          = 2,
  parameter int SIZE_W            = $clog2(NUM_WORDS_IN_LINE + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mannix_mem_read_responder_if.slave   bus
);

  localparam int IDX_W  = $clog2(NUM_WORDS_IN_LINE);
  localparam int LINE_W = NUM_WORDS_IN_LINE * WORD_WIDTH;

  resp_state_e           state_reg;
  resp_state_e           state_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [SIZE_W-1:0]     size_reg;
  logic [SIZE_W-1:0]     cnt_reg;
  logic                  gnt_reg;
  logic [LINE_W-1:0]     rd_data_reg;

  logic [SIZE_W-1:0]     size_clamped;
  logic                  capture;
  logic                  issue_last;

  logic                  sram_cs_next;
  logic [ADDR_WIDTH-1:0] sram_addr_next;
  logic                  rd_valid_next;
  logic                  rd_busy_next;

  logic                  pipe_out_valid;
  logic [IDX_W-1:0]      pipe_out_idx;
  logic                  pipe_pending;

  assign size_clamped = (bus.rd_size > SIZE_W'(NUM_WORDS_IN_LINE))
                      ? SIZE_W'(NUM_WORDS_IN_LINE) : bus.rd_size;
  assign capture      = (state_reg == IDLE) && bus.rd_req;
  assign issue_last   = (cnt_reg == size_reg - SIZE_W'(1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // A zero-length request spends its gnt cycle in DRAIN (the pipe is
        // already empty), so rd_gnt and rd_valid never land in one cycle.
        if (bus.rd_req) begin
          state_next = (size_clamped != '0) ? ISSUE : DRAIN;
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!pipe_pending) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    sram_cs_next   = 1'b0;
    sram_addr_next = '0;
    rd_valid_next  = 1'b0;
    rd_busy_next   = (state_reg != IDLE);
    case (state_reg)
      ISSUE: begin
        sram_cs_next   = 1'b1;
        // Address wraps modulo 2^ADDR_WIDTH by truncation.
        sram_addr_next = addr_reg + ADDR_WIDTH'(cnt_reg);
      end
      RESP: begin
        rd_valid_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------- request capture and line assembly ----------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      addr_reg    <= '0;
      size_reg    <= '0;
      cnt_reg     <= '0;
      gnt_reg     <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      gnt_reg <= capture;
      if (capture) begin
        addr_reg    <= bus.rd_addr;
        size_reg    <= size_clamped;
        cnt_reg     <= '0;
        rd_data_reg <= '0;
      end else begin
        if (state_reg == ISSUE) begin
          cnt_reg <= cnt_reg + SIZE_W'(1);
        end
        if (pipe_out_valid) begin
          rd_data_reg[int'(pipe_out_idx)*WORD_WIDTH +: WORD_WIDTH] <= bus.sram_rdata;
        end
      end
    end
  end

  mannix_lat_pipe #(
    .LAT   (SRAM_LAT),
    .IDX_W (IDX_W)
  ) u_lat_pipe (
    .clk       (clk),
    .flush     (rst_n),
    .in_valid  (sram_cs_next),
    .in_idx    (cnt_reg[IDX_W-1:0]),
    .out_valid (pipe_out_valid),
    .out_idx   (pipe_out_idx),
    .pending   (pipe_pending)
  );

  assign bus.rd_gnt    = gnt_reg;
  assign bus.rd_data   = rd_data_reg;
  assign bus.rd_valid  = rd_valid_next;
  assign bus.rd_busy   = rd_busy_next;
  assign bus.sram_cs   = sram_cs_next;
  assign bus.sram_addr = sram_addr_next;

endmodule
